// File: rtl/backend_pkg.sv
// Shared backend definitions: default stream geometry and the arbiter state type.
package backend_pkg;

  localparam int LENGTH   = 128;
  localparam int NMODULES = 4;
  localparam int SRC_W    = $clog2(NMODULES);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rx_stream_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder. Returns the first set
// request found searching last+1, last+2, ... with wrap-around, so the
// module served most recently has the lowest priority.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         any,
  output logic [W-1:0] idx
);

  // Scan from the farthest candidate back to the nearest so the nearest
  // requester after last is the final (winning) assignment.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        any = 1'b1;
        idx = W'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/rx_stream_arbiter.sv
// rx_stream_arbiter: round-robin merge of the per-module frontend event
// streams into the single gigex transmit stream. Bursts are bounded to
// MAX_BURST beats; every grant costs one idle arbitration cycle.
// Optional feature macro: ARB_STALL_CNT_EN adds the saturating stall_count
// output (cycles with out_valid high and out_ready low).
module rx_stream_arbiter #(
  parameter int NMODULES  = 4,
  parameter int LENGTH    = 128,
  parameter int MAX_BURST = 16
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic [NMODULES*LENGTH-1:0]    in_data,
  input  logic [NMODULES-1:0]           in_valid,
  output logic [NMODULES-1:0]           in_ready,
  output logic [LENGTH-1:0]             out_data,
  output logic [$clog2(NMODULES)-1:0]   out_src,
  output logic                          out_valid,
  input  logic                          out_ready
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [31:0]                   stall_count
`endif
);

  import backend_pkg::arb_state_t;
  import backend_pkg::IDLE;
  import backend_pkg::GRANT;

  localparam int IDX_W  = $clog2(NMODULES);
  localparam int BCNT_W = $clog2(MAX_BURST + 1);

  arb_state_t              state_reg, state_next;
  logic [IDX_W-1:0]        g_reg, g_next;
  logic [IDX_W-1:0]        last_reg, last_next;
  logic [BCNT_W-1:0]       bcnt_reg, bcnt_next;
  logic [BCNT_W-1:0]       bcnt_inc;
  logic [LENGTH-1:0]       out_data_reg;
  logic [IDX_W-1:0]        out_src_reg;
  logic                    out_valid_reg;

  logic                    pick_any;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pipe_ready;
  logic                    xfer;
  logic [LENGTH-1:0]       sel_word;

  rr_pick #(
    .N (NMODULES),
    .W (IDX_W)
  ) u_pick (
    .req  (in_valid),
    .last (last_reg),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // The output register can take a new word when empty or being drained.
  assign pipe_ready = ~out_valid_reg | out_ready;
  assign xfer       = (state_reg == GRANT) & in_valid[g_reg] & pipe_ready;
  assign sel_word   = in_data[int'(g_reg)*LENGTH +: LENGTH];
  assign bcnt_inc   = bcnt_reg + 1'b1;

  // Only the granted module sees ready, and only while the pipe can accept.
  for (genvar gi = 0; gi < NMODULES; gi++) begin : g_ready
    assign in_ready[gi] = (state_reg == GRANT) && (g_reg == IDX_W'(gi)) && pipe_ready;
  end

  // Next-state: pick a module in IDLE, count beats and decide release in GRANT.
  always_comb begin
    state_next = state_reg;
    g_next     = g_reg;
    last_next  = last_reg;
    bcnt_next  = bcnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          g_next     = pick_idx;
          bcnt_next  = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          bcnt_next = bcnt_inc;
        end
        // An empty source releases even while the output is stalled.
        if (!in_valid[g_reg] || (xfer && (bcnt_inc == BCNT_W'(MAX_BURST)))) begin
          state_next = IDLE;
          last_next  = g_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Arbitration state registers; last starts at the top index so module 0 wins first.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      g_reg     <= '0;
      last_reg  <= IDX_W'(NMODULES - 1);
      bcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      g_reg     <= g_next;
      last_reg  <= last_next;
      bcnt_reg  <= bcnt_next;
    end
  end

  // Output register: load on handshake, drop valid when drained with nothing new.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else if (xfer) begin
      out_data_reg  <= sel_word;
      out_src_reg   <= g_reg;
      out_valid_reg <= 1'b1;
    end else if (pipe_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;
  assign out_valid = out_valid_reg;

`ifdef ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  // Count back-pressured cycles, saturating at all-ones.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (out_valid_reg && !out_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_count = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Testbench for rx_stream_arbiter. Two instances: dut_a (MAX_BURST=16) and
// dut_b (MAX_BURST=1). Sources are modelled as FIFOs of random words; the
// expected output stream is predicted from a burst-level schedule model.
module tb_rx_stream_arbiter;

  localparam int NM   = 4;
  localparam int L    = 128;
  localparam int SW   = 2;
  localparam int MAXW = 64;
  localparam int LOGN = 512;

  logic sys_clk = 1'b0;
  logic rst;
  always #5 sys_clk = ~sys_clk;

  logic [NM*L-1:0] a_in_data, b_in_data;
  logic [NM-1:0]   a_in_valid, a_in_ready, b_in_valid, b_in_ready;
  logic [L-1:0]    a_out_data, b_out_data;
  logic [SW-1:0]   a_out_src, b_out_src;
  logic            a_out_valid, a_out_ready, b_out_valid, b_out_ready;
`ifdef ARB_STALL_CNT_EN
  logic [31:0]     a_stall, b_stall;
`endif

  rx_stream_arbiter #(.NMODULES(NM), .LENGTH(L), .MAX_BURST(16)) dut_a (
    .sys_clk(sys_clk), .rst(rst),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_src(a_out_src), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
`ifdef ARB_STALL_CNT_EN
    , .stall_count(a_stall)
`endif
  );

  rx_stream_arbiter #(.NMODULES(NM), .LENGTH(L), .MAX_BURST(1)) dut_b (
    .sys_clk(sys_clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_src(b_out_src), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
`ifdef ARB_STALL_CNT_EN
    , .stall_count(b_stall)
`endif
  );

  // Source FIFOs (stimulus side) and output logs.
  logic [L-1:0] a_words [NM][MAXW];
  logic [L-1:0] b_words [NM][MAXW];
  int a_wr [NM], a_rd [NM], b_wr [NM], b_rd [NM];
  int a_log_src [LOGN], b_log_src [LOGN];
  int a_log_cyc [LOGN], b_log_cyc [LOGN];
  logic [L-1:0] a_log_data [LOGN], b_log_data [LOGN];
  int a_nlog, b_nlog;
  logic [NM-1:0] a_ready_seen;
  int a_multi, b_multi;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Expected schedule produced by the reference model.
  int exp_src [LOGN], exp_idx [LOGN], exp_cyc [LOGN];
  int n_exp;
  int sched_cnt [NM];

  task automatic drive();
    for (int m = 0; m < NM; m++) begin
      a_in_valid[m] = (a_rd[m] < a_wr[m]);
      if (a_in_valid[m]) a_in_data[m*L +: L] = a_words[m][a_rd[m]];
      else               a_in_data[m*L +: L] = {4{$urandom}};
      b_in_valid[m] = (b_rd[m] < b_wr[m]);
      if (b_in_valid[m]) b_in_data[m*L +: L] = b_words[m][b_rd[m]];
      else               b_in_data[m*L +: L] = {4{$urandom}};
    end
  endtask

  task automatic clear_queues();
    for (int m = 0; m < NM; m++) begin
      a_wr[m] = 0; a_rd[m] = 0; b_wr[m] = 0; b_rd[m] = 0;
    end
    a_nlog = 0; b_nlog = 0; a_ready_seen = '0; a_multi = 0; b_multi = 0;
    drive();
  endtask

  task automatic load(input int m, input int n, input bit on_b);
    for (int k = 0; k < n; k++) begin
      if (on_b) b_words[m][b_wr[m] + k] = {$urandom, $urandom, $urandom, $urandom};
      else      a_words[m][a_wr[m] + k] = {$urandom, $urandom, $urandom, $urandom};
    end
    if (on_b) b_wr[m] += n;
    else      a_wr[m] += n;
  endtask

  // One clock cycle: sample handshakes and output beats, then pop the FIFOs.
  task automatic step();
    logic [NM-1:0] hs_a, hs_b;
    #1;
    hs_a = a_in_valid & a_in_ready;
    hs_b = b_in_valid & b_in_ready;
    a_ready_seen |= a_in_ready;
    if (!$onehot0(a_in_ready)) a_multi++;
    if (!$onehot0(b_in_ready)) b_multi++;
    if (a_out_valid && a_out_ready && a_nlog < LOGN) begin
      a_log_src[a_nlog] = int'(a_out_src); a_log_data[a_nlog] = a_out_data;
      a_log_cyc[a_nlog] = cyc; a_nlog++;
    end
    if (b_out_valid && b_out_ready && b_nlog < LOGN) begin
      b_log_src[b_nlog] = int'(b_out_src); b_log_data[b_nlog] = b_out_data;
      b_log_cyc[b_nlog] = cyc; b_nlog++;
    end
    @(posedge sys_clk);
    #1;
    cyc++;
    for (int m = 0; m < NM; m++) begin
      if (hs_a[m]) a_rd[m]++;
      if (hs_b[m]) b_rd[m]++;
    end
    drive();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    clear_queues();
    repeat (2) @(posedge sys_clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model: bursts of min(MAX_BURST, remaining) in round-robin order
  // starting after module NM-1. A burst cut by the limit costs one bubble
  // cycle, a burst that empties its source costs two (empty seen, then IDLE).
  task automatic build_schedule(input int maxb, input int t0);
    int rem [NM];
    int taken [NM];
    int lst, h, m, k;
    bit found;
    lst = NM - 1; h = t0 + 1; n_exp = 0; m = 0;
    for (int i = 0; i < NM; i++) begin rem[i] = sched_cnt[i]; taken[i] = 0; end
    do begin
      found = 1'b0;
      for (int s = 1; s <= NM; s++) begin
        if (!found && rem[(lst + s) % NM] > 0) begin found = 1'b1; m = (lst + s) % NM; end
      end
      if (found) begin
        k = (rem[m] < maxb) ? rem[m] : maxb;
        for (int j = 0; j < k; j++) begin
          exp_src[n_exp] = m; exp_idx[n_exp] = taken[m] + j; exp_cyc[n_exp] = h + j + 1;
          n_exp++;
        end
        taken[m] += k; rem[m] -= k; lst = m;
        h += (k == maxb) ? k + 1 : k + 2;
      end
    end while (found);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_out_src !== '0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b src=%0d data=%h, required 0/0/0", a_out_valid, a_out_src, a_out_data);
    end
    n_checks++;
    if (a_in_ready !== '0 || b_in_ready !== '0 || b_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: a_in_ready=%b b_in_ready=%b b_valid=%b, required 0", a_in_ready, b_in_ready, b_out_valid);
    end
`ifdef ARB_STALL_CNT_EN
    n_checks++;
    if (a_stall !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_stall: got %0d required 0", a_stall);
    end
`endif
    rst = 1'b0;
    repeat (3) step();
    n_checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: valid=%b in_ready=%b, required 0/0", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_single();
    int t0;
    apply_reset();
    sched_cnt = '{0, 0, 5, 0};
    t0 = cyc;
    load(2, 5, 1'b0);
    drive();
    build_schedule(16, t0);
    for (int c = 0; c < 100 && a_nlog < n_exp; c++) step();
    repeat (4) step();
    n_checks++;
    if (a_nlog !== n_exp) begin
      n_fail++;
      $display("FAIL single_count: got %0d beats required %0d", a_nlog, n_exp);
    end
    for (int i = 0; i < n_exp && i < a_nlog; i++) begin
      n_checks++;
      if (a_log_src[i] !== exp_src[i] || a_log_cyc[i] !== exp_cyc[i] ||
          a_log_data[i] !== a_words[exp_src[i]][exp_idx[i]]) begin
        n_fail++;
        $display("FAIL single_beat%0d: src=%0d cyc=%0d, required src=%0d cyc=%0d (data match=%0d)",
                 i, a_log_src[i], a_log_cyc[i], exp_src[i], exp_cyc[i],
                 a_log_data[i] === a_words[exp_src[i]][exp_idx[i]]);
      end
    end
    n_checks++;
    if (a_ready_seen !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready_seen: got %b required 0100", a_ready_seen);
    end
    n_checks++;
    if (a_in_ready !== '0 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_back_idle: in_ready=%b valid=%b required 0/0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_all_busy();
    int t0;
    apply_reset();
    sched_cnt = '{40, 40, 40, 40};
    t0 = cyc;
    for (int m = 0; m < NM; m++) load(m, 40, 1'b0);
    drive();
    build_schedule(16, t0);
    for (int c = 0; c < 600 && a_nlog < n_exp; c++) step();
    repeat (4) step();
    n_checks++;
    if (a_nlog !== n_exp) begin
      n_fail++;
      $display("FAIL busy_count: got %0d beats required %0d", a_nlog, n_exp);
    end
    for (int i = 0; i < n_exp && i < a_nlog; i++) begin
      n_checks++;
      if (a_log_src[i] !== exp_src[i] || a_log_cyc[i] !== exp_cyc[i] ||
          a_log_data[i] !== a_words[exp_src[i]][exp_idx[i]]) begin
        n_fail++;
        $display("FAIL busy_beat%0d: src=%0d cyc=%0d, required src=%0d cyc=%0d (data match=%0d)",
                 i, a_log_src[i], a_log_cyc[i], exp_src[i], exp_cyc[i],
                 a_log_data[i] === a_words[exp_src[i]][exp_idx[i]]);
      end
    end
    n_checks++;
    if (a_multi !== 0) begin
      n_fail++;
      $display("FAIL busy_onehot_ready: %0d cycles with several in_ready, required 0", a_multi);
    end
  endtask

  task automatic test_burst1();
    int t0;
    apply_reset();
    sched_cnt = '{6, 0, 0, 6};
    t0 = cyc;
    load(0, 6, 1'b1);
    load(3, 6, 1'b1);
    drive();
    build_schedule(1, t0);
    for (int c = 0; c < 200 && b_nlog < n_exp; c++) step();
    repeat (4) step();
    n_checks++;
    if (b_nlog !== n_exp) begin
      n_fail++;
      $display("FAIL burst1_count: got %0d beats required %0d", b_nlog, n_exp);
    end
    for (int i = 0; i < n_exp && i < b_nlog; i++) begin
      n_checks++;
      if (b_log_src[i] !== exp_src[i] || b_log_cyc[i] !== exp_cyc[i] ||
          b_log_data[i] !== b_words[exp_src[i]][exp_idx[i]]) begin
        n_fail++;
        $display("FAIL burst1_beat%0d: src=%0d cyc=%0d, required src=%0d cyc=%0d",
                 i, b_log_src[i], b_log_cyc[i], exp_src[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    load(1, 30, 1'b0);
    drive();
    for (int c = 0; c < 50 && a_nlog < 5; c++) step();
    a_out_ready = 1'b0;
    for (int s = 0; s < 10; s++) begin
      #1;
      n_checks++;
      if (a_in_ready !== '0 || a_out_valid !== 1'b1 || a_out_data !== a_words[1][5]) begin
        n_fail++;
        $display("FAIL stall_hold%0d: in_ready=%b valid=%b data=%h, required 0/1/%h",
                 s, a_in_ready, a_out_valid, a_out_data, a_words[1][5]);
      end
      step();
    end
    a_out_ready = 1'b1;
    for (int c = 0; c < 200 && a_nlog < 30; c++) step();
    repeat (3) step();
    n_checks++;
    if (a_nlog !== 30) begin
      n_fail++;
      $display("FAIL stall_count_beats: got %0d required 30", a_nlog);
    end
    for (int i = 0; i < 30 && i < a_nlog; i++) begin
      n_checks++;
      if (a_log_src[i] !== 1 || a_log_data[i] !== a_words[1][i]) begin
        n_fail++;
        $display("FAIL stall_beat%0d: src=%0d data=%h required src=1 data=%h",
                 i, a_log_src[i], a_log_data[i], a_words[1][i]);
      end
    end
    if (a_nlog >= 17) begin
      n_checks++;
      if (a_log_cyc[15] - a_log_cyc[0] !== 25 || a_log_cyc[16] - a_log_cyc[15] !== 2) begin
        n_fail++;
        $display("FAIL stall_burst_timing: span=%0d gap=%0d required 25/2",
                 a_log_cyc[15] - a_log_cyc[0], a_log_cyc[16] - a_log_cyc[15]);
      end
    end
`ifdef ARB_STALL_CNT_EN
    n_checks++;
    if (a_stall !== 32'd10) begin
      n_fail++;
      $display("FAIL stall_counter: got %0d required 10", a_stall);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int rd3;
    apply_reset();
    load(3, 20, 1'b0);
    drive();
    for (int c = 0; c < 50 && a_nlog < 4; c++) step();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== '0) begin
      n_fail++;
      $display("FAIL midreset_immediate: valid=%b in_ready=%b required 0/0", a_out_valid, a_in_ready);
    end
    rd3 = a_rd[3];
    load(0, 5, 1'b0);
    drive();
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    a_nlog = 0;
    for (int c = 0; c < 200 && a_nlog < 5 + (20 - rd3); c++) step();
    n_checks++;
    if (a_nlog !== 5 + (20 - rd3)) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d required %0d", a_nlog, 5 + (20 - rd3));
    end
    n_checks++;
    if (a_log_src[0] !== 0 || a_log_data[0] !== a_words[0][0]) begin
      n_fail++;
      $display("FAIL midreset_first: src=%0d required 0", a_log_src[0]);
    end
    n_checks++;
    if (a_log_src[5] !== 3 || a_log_data[5] !== a_words[3][rd3]) begin
      n_fail++;
      $display("FAIL midreset_resume: src=%0d data=%h required 3/%h", a_log_src[5], a_log_data[5], a_words[3][rd3]);
    end
  endtask

  task automatic test_random();
    int total;
    int nexp [NM];
    for (int rep = 0; rep < 3; rep++) begin
      apply_reset();
      total = 0;
      for (int m = 0; m < NM; m++) begin
        int n;
        n = $urandom_range(0, 30);
        load(m, n, 1'b0);
        total += n;
        nexp[m] = 0;
      end
      drive();
      for (int c = 0; c < 3000 && a_nlog < total; c++) begin
        a_out_ready = ($urandom_range(0, 9) < 7);
        step();
      end
      a_out_ready = 1'b1;
      repeat (3) step();
      n_checks++;
      if (a_nlog !== total) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d beats required %0d", rep, a_nlog, total);
      end
      for (int i = 0; i < a_nlog; i++) begin
        int s;
        s = a_log_src[i];
        n_checks++;
        if (s >= NM || nexp[s] >= a_wr[s] || a_log_data[i] !== a_words[s][nexp[s]]) begin
          n_fail++;
          $display("FAIL rand%0d_beat%0d: src=%0d data=%h does not match next word of that module", rep, i, s, a_log_data[i]);
        end
        if (s < NM) nexp[s]++;
      end
      n_checks++;
      if (a_multi !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_onehot_ready: %0d cycles with several in_ready, required 0", rep, a_multi);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    clear_queues();
    test_reset();
    test_single();
    test_all_busy();
    test_burst1();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
